// File: rtl/video_scanout_if.sv
// Renderer <-> scan-out link: back-buffer write port plus the per-line render handshake.
interface video_scanout_if #(
    parameter int AW = 10
);
    logic          lb_wr_en;
    logic [AW-1:0] lb_wr_addr;
    logic [7:0]    lb_wr_data;
    logic          render_done;
    logic          render_start;
    logic [8:0]    render_line;
    logic          underrun;

    modport master (
        output lb_wr_en, lb_wr_addr, lb_wr_data, render_done,
        input  render_start, render_line, underrun
    );

    modport slave (
        input  lb_wr_en, lb_wr_addr, lb_wr_data, render_done,
        output render_start, render_line, underrun
    );
endinterface

// File: rtl/video_scanout.sv
// Line-buffer scan-out: ping-pong line buffers, horizontal scaling, palette lookup.
// Output for a pixel slot appears exactly 2 clocks after the slot.
module video_scanout #(
    parameter int LINE_WIDTH = 640,
    parameter int AW         = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                next_frame,
    input  logic                next_line,
    input  logic                next_pixel,
    input  logic [7:0]          hscale,
    input  logic [7:0]          border_idx,
    video_scanout_if.slave      rnd,
    input  logic                pal_wr_en,
    input  logic [7:0]          pal_wr_addr,
    input  logic [11:0]         pal_wr_data,
    output logic [11:0]         palette_rgb_data
);
    localparam logic [AW:0] LW = (AW+1)'(LINE_WIDTH);

    logic          front_sel;
    logic          done_flag;
    logic          line_ok;
    logic [15:0]   x_acc;
    logic [16:0]   x_sum;
    logic [AW-1:0] rd_addr;
    logic          out_of_range;

    logic [7:0]    lb_mem [0:(2**(AW+1))-1];
    logic [7:0]    lb_q;
    logic          border_q;

    logic [11:0]   pal_mem [0:255];
    logic [7:0]    pal_idx;

    always_comb begin
        x_sum        = {1'b0, x_acc} + {9'b0, hscale};
        rd_addr      = x_acc[AW+5:6];
        out_of_range = ({1'b0, rd_addr} >= LW);
        pal_idx      = border_q ? border_idx : lb_q;
    end

    // Line control and S0 accumulator. A render_done coinciding with the swap
    // still validates the line being swapped in.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel        <= 1'b0;
            done_flag        <= 1'b0;
            line_ok          <= 1'b0;
            x_acc            <= '0;
            rnd.render_start <= 1'b0;
            rnd.render_line  <= '0;
            rnd.underrun     <= 1'b0;
        end else begin
            rnd.render_start <= next_line;
            rnd.underrun     <= next_line && !(done_flag || rnd.render_done);
            if (next_frame)
                rnd.render_line <= '0;
            else if (next_line)
                rnd.render_line <= rnd.render_line + 9'd1;
            if (next_line) begin
                front_sel <= ~front_sel;
                x_acc     <= '0;
                line_ok   <= done_flag || rnd.render_done;
                done_flag <= 1'b0;
            end else begin
                if (rnd.render_done)
                    done_flag <= 1'b1;
                if (next_pixel)
                    x_acc <= x_sum[16] ? '1 : x_sum[15:0];
            end
        end
    end

    // Back buffer is the half not being displayed, so reads and writes never collide.
    always_ff @(posedge clk) begin
        if (rnd.lb_wr_en)
            lb_mem[{~front_sel, rnd.lb_wr_addr}] <= rnd.lb_wr_data;
        lb_q <= lb_mem[{front_sel, rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (rst)
            border_q <= 1'b1;
        else
            border_q <= out_of_range || !line_ok;
    end

    always_ff @(posedge clk) begin
        if (pal_wr_en)
            pal_mem[pal_wr_addr] <= pal_wr_data;
    end

    // Separate process from the write: a same-entry write in this clock yields the old colour.
    always_ff @(posedge clk) begin
        if (rst)
            palette_rgb_data <= '0;
        else
            palette_rgb_data <= pal_mem[pal_idx];
    end
endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout: scaling, palette mapping, underrun, line counting.
module tb_video_scanout;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_frame, next_line, next_pixel;
    logic [7:0]  hscale, border_idx;
    logic        pal_wr_en;
    logic [7:0]  pal_wr_addr;
    logic [11:0] pal_wr_data;
    logic [11:0] palette_rgb_data;

    video_scanout_if #(.AW(AW)) rif ();

    video_scanout #(.LINE_WIDTH(640), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .next_frame       (next_frame),
        .next_line        (next_line),
        .next_pixel       (next_pixel),
        .hscale           (hscale),
        .border_idx       (border_idx),
        .rnd              (rif),
        .pal_wr_en        (pal_wr_en),
        .pal_wr_addr      (pal_wr_addr),
        .pal_wr_data      (pal_wr_data),
        .palette_rgb_data (palette_rgb_data)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [11:0] pal_m [256];
    logic [7:0]  lb_m  [2][1024];
    logic [11:0] cap   [820];
    bit          m_front, m_done, m_ok;
    logic [8:0]  m_line;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_px(input int x);
        int acc;
        int a;
        logic [7:0] idx;
        acc = x * int'(hscale);
        if (acc > 65535) acc = 65535;
        a = acc >> 6;
        if (a >= 640 || !m_ok) idx = border_idx;
        else idx = lb_m[m_front][a];
        return pal_m[idx];
    endfunction

    task automatic fill(input int mode);
        for (int a = 0; a < 640; a++) begin
            rif.lb_wr_en   = 1'b1;
            rif.lb_wr_addr = 10'(a);
            case (mode)
                0:       rif.lb_wr_data = 8'(a);
                1:       rif.lb_wr_data = 8'(a % 200);
                default: rif.lb_wr_data = 8'd5;
            endcase
            lb_m[!m_front][a] = rif.lb_wr_data;
            tick();
        end
        rif.lb_wr_en = 1'b0;
    endtask

    task automatic rdone();
        rif.render_done = 1'b1;
        tick();
        rif.render_done = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic nl(input bit frame, input bit done_too);
        bit exp_u;
        next_line = 1'b1;
        next_frame = frame;
        rif.render_done = done_too;
        tick();
        next_line = 1'b0;
        next_frame = 1'b0;
        rif.render_done = 1'b0;
        exp_u   = !(m_done || done_too);
        m_ok    = !exp_u;
        m_done  = 1'b0;
        m_front = !m_front;
        m_line  = frame ? 9'd0 : m_line + 9'd1;
        chk("underrun", 16'(rif.underrun), 16'(exp_u));
        chk("render_start", 16'(rif.render_start), 16'd1);
        chk("render_line", 16'(rif.render_line), 16'(m_line));
    endtask

    task automatic capture(input int n, input int pw_at, input logic [11:0] pw_data);
        for (int j = 0; j < n; j++) begin
            cap[j] = palette_rgb_data;
            if (j == 1) begin
                chk("render_start_drop", 16'(rif.render_start), 16'd0);
                chk("underrun_drop", 16'(rif.underrun), 16'd0);
            end
            if (j == pw_at) begin
                pal_wr_en   = 1'b1;
                pal_wr_addr = 8'd5;
                pal_wr_data = pw_data;
            end
            tick();
            pal_wr_en = 1'b0;
        end
    endtask

    task automatic check_line(input int n, input string tag);
        for (int x = 0; x < n - 2; x++)
            chk($sformatf("%s px%0d", tag, x), 16'(cap[x + 2]), 16'(exp_px(x)));
    endtask

    initial begin
        rst = 1'b1;
        next_frame = 1'b0; next_line = 1'b0; next_pixel = 1'b1;
        hscale = 8'h40; border_idx = 8'h3C;
        pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
        rif.lb_wr_en = 1'b0; rif.lb_wr_addr = '0; rif.lb_wr_data = '0;
        rif.render_done = 1'b0;
        m_front = 1'b0; m_done = 1'b0; m_ok = 1'b0; m_line = '0;
        repeat (3) tick();
        chk("rst rgb", 16'(palette_rgb_data), 16'h000);
        chk("rst render_start", 16'(rif.render_start), 16'd0);
        chk("rst render_line", 16'(rif.render_line), 16'd0);
        chk("rst underrun", 16'(rif.underrun), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            pal_wr_en = 1'b1;
            pal_wr_addr = 8'(i);
            pal_wr_data = 12'(i * 12'h111);
            pal_m[i] = pal_wr_data;
            tick();
        end
        pal_wr_en = 1'b0;

        // 1:1 line, including border past the buffer end
        fill(0); rdone(); nl(1'b1, 1'b0);
        capture(800, -1, '0); check_line(800, "s1");

        // 2x zoom, then half-scale with done coinciding with the swap
        hscale = 8'h20;
        fill(0); rdone(); nl(1'b0, 1'b0);
        capture(400, -1, '0); check_line(400, "z2");
        hscale = 8'h80;
        fill(0); nl(1'b0, 1'b1);
        capture(400, -1, '0); check_line(400, "z05");

        // underrun line, then a normal line
        hscale = 8'h40;
        fill(0); nl(1'b0, 1'b0);
        capture(300, -1, '0); check_line(300, "urun");
        fill(0); rdone(); nl(1'b0, 1'b0);
        capture(300, -1, '0); check_line(300, "recov");

        // frame restart and line counting
        nl(1'b1, 1'b0);
        nl(1'b0, 1'b0); nl(1'b0, 1'b0); nl(1'b0, 1'b0);
        chk("line3", 16'(rif.render_line), 16'd3);

        // palette write colliding with a read of the same entry
        fill(2); rdone(); nl(1'b0, 1'b0);
        capture(20, 10, 12'hABC);
        chk("pal pre", 16'(cap[10]), 16'h555);
        chk("pal same clk", 16'(cap[11]), 16'h555);
        chk("pal next", 16'(cap[12]), 16'hABC);
        chk("pal later", 16'(cap[15]), 16'hABC);
        pal_m[5] = 12'hABC;

        // max step: out-of-range border and accumulator saturation
        hscale = 8'hFF; border_idx = 8'hFF;
        fill(1); rdone(); nl(1'b0, 1'b0);
        capture(800, -1, '0); check_line(800, "sat");

        // reset mid-line discards a pending render_done
        hscale = 8'h40;
        fill(0); rdone();
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        m_front = 1'b0; m_done = 1'b0; m_ok = 1'b0; m_line = '0;
        chk("mid rst rgb", 16'(palette_rgb_data), 16'h000);
        chk("mid rst line", 16'(rif.render_line), 16'd0);
        nl(1'b0, 1'b0);
        capture(100, -1, '0); check_line(100, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
